// File: rtl/fft_butterfly_if.sv
// fft_butterfly_if: operand/result bundle between the memory/AGU side and the butterfly
interface fft_butterfly_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                         en;
  logic                         in_valid;
  logic signed [DATA_WIDTH-1:0] A_real_in;
  logic signed [DATA_WIDTH-1:0] A_imag_in;
  logic signed [DATA_WIDTH-1:0] B_real_in;
  logic signed [DATA_WIDTH-1:0] B_imag_in;
  logic        [ADDR_WIDTH-1:0] addr_Twiddle;
  logic                         out_valid;
  logic signed [DATA_WIDTH-1:0] A_real_out;
  logic signed [DATA_WIDTH-1:0] A_imag_out;
  logic signed [DATA_WIDTH-1:0] B_real_out;
  logic signed [DATA_WIDTH-1:0] B_imag_out;
  modport master (
    output en, in_valid, A_real_in, A_imag_in, B_real_in, B_imag_in, addr_Twiddle,
    input  out_valid, A_real_out, A_imag_out, B_real_out, B_imag_out
  );
  modport slave (
    input  en, in_valid, A_real_in, A_imag_in, B_real_in, B_imag_in, addr_Twiddle,
    output out_valid, A_real_out, A_imag_out, B_real_out, B_imag_out
  );
endinterface

// File: rtl/fft_butterfly.sv
// fft_butterfly: 4-stage pipelined radix-2 DIT butterfly, A' = (A + W*B) >> SCALE, B' = (A - W*B) >> SCALE
module fft_butterfly #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int TW_WIDTH   = 8,
  parameter int SCALE      = 1
) (
  input logic            clk,
  input logic            clr,
  fft_butterfly_if.slave bus
);
  localparam int  DW  = DATA_WIDTH;
  localparam int  TW  = TW_WIDTH;
  localparam int  N   = 1 << ADDR_WIDTH;
  localparam int  H   = N / 2;
  localparam int  PW  = 2 * ((DW > TW) ? DW : TW);
  localparam real PI  = 3.141592653589793;
  localparam real ONE = real'(1 << (TW - 2));
  localparam logic signed [PW:0] RND = (PW + 1)'(1) << (TW - 3);

  function automatic int rnd(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
  endfunction

  function automatic logic signed [PW-1:0] dx(input logic signed [DW-1:0] x);
    return $signed({{(PW - DW){x[DW-1]}}, x});
  endfunction

  function automatic logic signed [PW-1:0] tx(input logic signed [TW-1:0] x);
    return $signed({{(PW - TW){x[TW-1]}}, x});
  endfunction

  function automatic logic signed [PW:0] px(input logic signed [PW-1:0] x);
    return $signed({x[PW-1], x});
  endfunction

  function automatic logic signed [DW+1:0] ax(input logic signed [DW-1:0] x);
    return $signed({{2{x[DW-1]}}, x});
  endfunction

  function automatic logic signed [DW+1:0] wx(input logic signed [DW:0] x);
    return $signed({x[DW], x});
  endfunction

  logic signed [TW-1:0] rom_re [H];
  logic signed [TW-1:0] rom_im [H];

  for (genvar k = 0; k < H; k++) begin : g_rom
    localparam logic signed [TW-1:0] WR = TW'(rnd(ONE * $cos(2.0 * PI * k / N)));
    localparam logic signed [TW-1:0] WI = TW'(-rnd(ONE * $sin(2.0 * PI * k / N)));
    assign rom_re[k] = WR;
    assign rom_im[k] = WI;
  end

  logic                 v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, v4_q, v4_d;
  logic signed [DW-1:0] ar1_q, ar1_d, ai1_q, ai1_d, br1_q, br1_d, bi1_q, bi1_d;
  logic signed [TW-1:0] wr1_q, wr1_d, wi1_q, wi1_d;
  logic signed [DW-1:0] ar2_q, ar2_d, ai2_q, ai2_d;
  logic signed [PW-1:0] mrr_q, mrr_d, mii_q, mii_d, mri_q, mri_d, mir_q, mir_d;
  logic signed [DW-1:0] ar3_q, ar3_d, ai3_q, ai3_d;
  logic signed [DW:0]   pr3_q, pr3_d, pi3_q, pi3_d;
  logic signed [DW-1:0] oar_q, oar_d, oai_q, oai_d, obr_q, obr_d, obi_q, obi_d;

  // next-state of every stage; data moves regardless of valid so bubbles cost nothing extra
  always_comb begin
    v1_d  = bus.in_valid;
    ar1_d = bus.A_real_in;
    ai1_d = bus.A_imag_in;
    br1_d = bus.B_real_in;
    bi1_d = bus.B_imag_in;
    wr1_d = rom_re[bus.addr_Twiddle[ADDR_WIDTH-2:0]];
    wi1_d = rom_im[bus.addr_Twiddle[ADDR_WIDTH-2:0]];
    v2_d  = v1_q;
    ar2_d = ar1_q;
    ai2_d = ai1_q;
    mrr_d = dx(br1_q) * tx(wr1_q);
    mii_d = dx(bi1_q) * tx(wi1_q);
    mri_d = dx(br1_q) * tx(wi1_q);
    mir_d = dx(bi1_q) * tx(wr1_q);
    v3_d  = v2_q;
    ar3_d = ar2_q;
    ai3_d = ai2_q;
    pr3_d = (DW + 1)'((px(mrr_q) - px(mii_q) + RND) >>> (TW - 2));
    pi3_d = (DW + 1)'((px(mri_q) + px(mir_q) + RND) >>> (TW - 2));
    v4_d  = v3_q;
    oar_d = DW'((ax(ar3_q) + wx(pr3_q)) >>> SCALE);
    oai_d = DW'((ax(ai3_q) + wx(pi3_q)) >>> SCALE);
    obr_d = DW'((ax(ar3_q) - wx(pr3_q)) >>> SCALE);
    obi_d = DW'((ax(ai3_q) - wx(pi3_q)) >>> SCALE);
  end

  // clr flushes the whole pipe; otherwise every stage advances together only when en is high
  always_ff @(posedge clk) begin
    if (clr) begin
      {v1_q, v2_q, v3_q, v4_q} <= '0;
      {ar1_q, ai1_q, br1_q, bi1_q, wr1_q, wi1_q} <= '0;
      {ar2_q, ai2_q, mrr_q, mii_q, mri_q, mir_q} <= '0;
      {ar3_q, ai3_q, pr3_q, pi3_q} <= '0;
      {oar_q, oai_q, obr_q, obi_q} <= '0;
    end else if (bus.en) begin
      v1_q  <= v1_d;
      ar1_q <= ar1_d;
      ai1_q <= ai1_d;
      br1_q <= br1_d;
      bi1_q <= bi1_d;
      wr1_q <= wr1_d;
      wi1_q <= wi1_d;
      v2_q  <= v2_d;
      ar2_q <= ar2_d;
      ai2_q <= ai2_d;
      mrr_q <= mrr_d;
      mii_q <= mii_d;
      mri_q <= mri_d;
      mir_q <= mir_d;
      v3_q  <= v3_d;
      ar3_q <= ar3_d;
      ai3_q <= ai3_d;
      pr3_q <= pr3_d;
      pi3_q <= pi3_d;
      v4_q  <= v4_d;
      oar_q <= oar_d;
      oai_q <= oai_d;
      obr_q <= obr_d;
      obi_q <= obi_d;
    end
  end

  assign bus.out_valid  = v4_q;
  assign bus.A_real_out = oar_q;
  assign bus.A_imag_out = oai_q;
  assign bus.B_real_out = obr_q;
  assign bus.B_imag_out = obi_q;
endmodule

// File: tb/tb_fft_butterfly.sv
// tb_fft_butterfly: table vectors, corner sequences and random traffic against a math model, for SCALE=1 and SCALE=0
module tb_fft_butterfly;
  logic clk = 1'b0;
  logic clr;
  logic t_en, t_iv;
  logic signed [7:0] t_ar, t_ai, t_br, t_bi;
  logic [2:0] t_k;

  always #5 clk = ~clk;

  fft_butterfly_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) b1 ();
  fft_butterfly_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) b0 ();

  assign b1.en = t_en;
  assign b1.in_valid = t_iv;
  assign b1.A_real_in = t_ar;
  assign b1.A_imag_in = t_ai;
  assign b1.B_real_in = t_br;
  assign b1.B_imag_in = t_bi;
  assign b1.addr_Twiddle = t_k;
  assign b0.en = t_en;
  assign b0.in_valid = t_iv;
  assign b0.A_real_in = t_ar;
  assign b0.A_imag_in = t_ai;
  assign b0.B_real_in = t_br;
  assign b0.B_imag_in = t_bi;
  assign b0.addr_Twiddle = t_k;

  fft_butterfly #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .TW_WIDTH(8), .SCALE(1)) dut1 (.clk(clk), .clr(clr), .bus(b1));
  fft_butterfly #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .TW_WIDTH(8), .SCALE(0)) dut0 (.clk(clk), .clr(clr), .bus(b0));

  typedef struct { int idx; int e1[4]; int e0[4]; } item_t;
  typedef struct { int k; int ar; int ai; int br; int bi; int x1[4]; int x0[4]; } vec_t;

  item_t q[$];
  item_t cur;
  bit    cur_v;
  int    cnt, n_cmp, n_err, ovc;
  vec_t  tv[6];

  function automatic int wrap(input int x, input int w);
    int m = 1 << w;
    int y = x & (m - 1);
    return (y >= m / 2) ? y - m : y;
  endfunction

  function automatic void model(input int ar, ai, br, bi, k, scale, output int e[4]);
    real th = 2.0 * 3.141592653589793 * (k % 4) / 8.0;
    int wr = $rtoi($floor(64.0 * $cos(th) + 0.5));
    int wi = -$rtoi($floor(64.0 * $sin(th) + 0.5));
    int pr = wrap((br * wr - bi * wi + 32) >>> 6, 9);
    int pim = wrap((br * wi + bi * wr + 32) >>> 6, 9);
    e[0] = wrap((ar + pr) >>> scale, 8);
    e[1] = wrap((ai + pim) >>> scale, 8);
    e[2] = wrap((ar - pr) >>> scale, 8);
    e[3] = wrap((ai - pim) >>> scale, 8);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input int e1[4], input int e0[4]);
    chk({nm, "_s1_a_re"}, int'(b1.A_real_out), e1[0]);
    chk({nm, "_s1_a_im"}, int'(b1.A_imag_out), e1[1]);
    chk({nm, "_s1_b_re"}, int'(b1.B_real_out), e1[2]);
    chk({nm, "_s1_b_im"}, int'(b1.B_imag_out), e1[3]);
    chk({nm, "_s0_a_re"}, int'(b0.A_real_out), e0[0]);
    chk({nm, "_s0_a_im"}, int'(b0.A_imag_out), e0[1]);
    chk({nm, "_s0_b_re"}, int'(b0.B_real_out), e0[2]);
    chk({nm, "_s0_b_im"}, int'(b0.B_imag_out), e0[3]);
  endtask

  task automatic cycle(input bit c, input bit e, input bit v, input int a_r, a_i, b_r, b_i, kk);
    item_t it;
    bit adv;
    int z[4];
    clr = c; t_en = e; t_iv = v;
    t_ar = 8'(a_r); t_ai = 8'(a_i); t_br = 8'(b_r); t_bi = 8'(b_i); t_k = 3'(kk);
    @(posedge clk);
    adv = 1'b0;
    if (c) begin
      q.delete();
      cur_v = 1'b0;
    end else if (e) begin
      cnt++;
      adv = 1'b1;
      if (v) begin
        it.idx = cnt;
        model(a_r, a_i, b_r, b_i, kk, 1, it.e1);
        model(a_r, a_i, b_r, b_i, kk, 0, it.e0);
        q.push_back(it);
      end
    end
    @(negedge clk);
    if (adv) begin
      if (q.size() > 0 && q[0].idx + 3 == cnt) begin
        cur = q.pop_front();
        cur_v = 1'b1;
      end else cur_v = 1'b0;
      if (b1.out_valid) ovc++;
    end
    chk("out_valid_s1", int'(b1.out_valid), int'(cur_v));
    chk("out_valid_s0", int'(b0.out_valid), int'(cur_v));
    if (c) begin
      z = '{0, 0, 0, 0};
      chk_out("clr_zero", z, z);
    end else if (cur_v) chk_out("model", cur.e1, cur.e0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cycle(0, 1, 0, $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
            $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128, $urandom_range(0, 7));
  endtask

  task automatic setv(input int i, k, ar, ai, br, bi, input int p0, p1, p2, p3, input int z0, z1, z2, z3);
    tv[i].k = k; tv[i].ar = ar; tv[i].ai = ai; tv[i].br = br; tv[i].bi = bi;
    tv[i].x1 = '{p0, p1, p2, p3};
    tv[i].x0 = '{z0, z1, z2, z3};
  endtask

  initial begin
    int d[8];
    n_cmp = 0; n_err = 0; cnt = 0; ovc = 0; cur_v = 1'b0;
    setv(0, 0, 10, 5, 4, -2, 7, 1, 3, 3, 14, 3, 6, 7);
    setv(1, 2, 10, 5, 4, -2, 4, 0, 6, 4, 8, 1, 12, 9);
    setv(2, 1, 0, 0, 64, 0, 22, -23, -23, 22, 45, -45, -45, 45);
    setv(3, 0, 127, 0, 127, 0, 127, 0, 0, 0, -2, 0, 0, 0);
    setv(4, 6, 10, 5, 4, -2, 4, 0, 6, 4, 8, 1, 12, 9);
    setv(5, 3, 0, 0, 64, 0, -23, -23, 22, 22, -45, -45, 45, 45);

    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 6; i++) begin
      cycle(0, 1, 1, tv[i].ar, tv[i].ai, tv[i].br, tv[i].bi, tv[i].k);
      idle(3);
      chk($sformatf("vec%0d_valid", i), int'(b1.out_valid), 1);
      chk_out($sformatf("vec%0d", i), tv[i].x1, tv[i].x0);
      idle(1);
    end

    for (int j = 0; j < 4; j++) d[j] = $urandom_range(0, 255) - 128;
    for (int j = 4; j < 8; j++) d[j] = $urandom_range(0, 255) - 128;
    ovc = 0;
    for (int j = 0; j < 8; j++) begin
      cycle(0, 1, 1, d[j % 4], d[(j + 1) % 4], d[4 + j % 4], d[4 + (j + 2) % 4], j);
      if (j == 4)
        for (int s = 0; s < 3; s++) cycle(0, 0, 1, 99, -99, 55, -55, 1);
    end
    idle(4);
    chk("burst_count", ovc, 8);

    ovc = 0;
    cycle(0, 1, 1, 50, -20, 33, 70, 1);
    idle(1);
    cycle(1, 1, 0, 0, 0, 0, 0, 0);
    idle(5);
    chk("clr_drop_count", ovc, 0);

    for (int i = 0; i < 500; i++)
      cycle($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
            $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128, $urandom_range(0, 7));
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
